// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - prioritised interrupt controller with edge/level sources and vector output
//
// Ports:
//   clk        clock, all state changes on rising edge
//   reset      asynchronous active-low reset
//   irq_in     asynchronous interrupt source lines (bit i = line i)
//   cfg_we     configuration write strobe
//   cfg_sel    register select: 0 MASK, 1 MODE, 2 PEND_CLR/PEND, 3 STATUS
//   cfg_wdata  write data, low NUM_IRQ bits used
//   cfg_rdata  combinational read of the selected register
//   int_req    registered interrupt request to the CPU
//   int_ack    single-cycle CPU acknowledge
//   eoi        single-cycle CPU end-of-interrupt
//   irq_id     index of the line in request/service
//   vector     handler address VEC_BASE + irq_id*VEC_STRIDE
//   busy       high while a request is being serviced
module int_ctrl #(
    parameter int          NUM_IRQ    = 8,
    parameter int          ADDR_W     = 16,
    parameter int unsigned VEC_BASE   = 16'h0100,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [15:0]        cfg_wdata,
    output logic [15:0]        cfg_rdata,
    output logic               int_req,
    input  logic               int_ack,
    input  logic               eoi,
    output logic [3:0]         irq_id,
    output logic [ADDR_W-1:0]  vector,
    output logic               busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SVC  = 2'd2;

    logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [1:0]         state_q, state_d;
    logic               int_req_q, int_req_d;
    logic               busy_q, busy_d;
    logic [3:0]         irq_id_q, irq_id_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pend_eff;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic [3:0]         win_id;
    logic [15:0]        rdata;

    // Every write-data bit is consumed here so narrow configurations stay lint-clean.
    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata;

    // Edge-mode lines latch rising edges; level-mode lines mirror the synchronised input.
    assign rise     = s2_q & ~s3_q & mode_q;
    assign pend_eff = (pend_q & mode_q) | (s2_q & ~mode_q);
    assign eligible = pend_eff & mask_q;

    // Lowest index wins: scan downward so the last assignment is the lowest set bit.
    always_comb begin
        win_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) win_id = 4'(i);
        end
    end

    always_comb begin
        mask_d    = mask_q;
        mode_d    = mode_q;
        clr       = '0;
        state_d   = state_q;
        int_req_d = int_req_q;
        busy_d    = busy_q;
        irq_id_d  = irq_id_q;

        if (cfg_we) begin
            case (cfg_sel)
                2'd0:    mask_d = cfg_wdata[NUM_IRQ-1:0];
                2'd1:    mode_d = cfg_wdata[NUM_IRQ-1:0];
                2'd2:    clr    = cfg_wdata[NUM_IRQ-1:0] & mode_q;
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    irq_id_d  = win_id;
                    int_req_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    int_req_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_SVC;
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        if (irq_id_q == 4'(i) && mode_q[i]) clr[i] = 1'b1;
                    end
                end
            end
            ST_SVC: begin
                if (eoi) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new edge on the same cycle as a clear keeps the line pending.
        pend_d = ((pend_q & ~clr) | rise) & mode_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            pend_q    <= '0;
            state_q   <= ST_IDLE;
            int_req_q <= 1'b0;
            busy_q    <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            s1_q      <= irq_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            state_q   <= state_d;
            int_req_q <= int_req_d;
            busy_q    <= busy_d;
            irq_id_q  <= irq_id_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (cfg_sel)
            2'd0:    rdata[NUM_IRQ-1:0] = mask_q;
            2'd1:    rdata[NUM_IRQ-1:0] = mode_q;
            2'd2:    rdata[NUM_IRQ-1:0] = pend_eff;
            default: rdata = {10'b0, busy_q, int_req_q, irq_id_q};
        endcase
    end

    assign cfg_rdata = rdata;
    assign int_req   = int_req_q;
    assign busy      = busy_q;
    assign irq_id    = irq_id_q;
    assign vector    = ADDR_W'(VEC_BASE + 32'(irq_id_q) * VEC_STRIDE);

endmodule
